// File: rtl/i2c_seq_pkg.sv
// Shared constants and types for the Wishbone-to-IICMB I2C transfer sequencer.
package i2c_seq_pkg;

   typedef enum logic [1:0] {
      REG_CSR  = 2'd0,
      REG_DPR  = 2'd1,
      REG_CMDR = 2'd2,
      REG_FSMR = 2'd3
   } reg_addr_t;

   localparam logic [7:0] CSR_ON  = 8'hC0;
   localparam logic [7:0] CSR_OFF = 8'h00;

   localparam logic [7:0] CMD_WRITE   = 8'h01;
   localparam logic [7:0] CMD_RD_ACK  = 8'h02;
   localparam logic [7:0] CMD_RD_NAK  = 8'h03;
   localparam logic [7:0] CMD_START   = 8'h04;
   localparam logic [7:0] CMD_STOP    = 8'h05;
   localparam logic [7:0] CMD_SET_BUS = 8'h06;

   localparam int RSP_DON = 7;
   localparam int RSP_NAK = 6;
   localparam int RSP_AL  = 5;
   localparam int RSP_ERR = 4;

   typedef enum logic [3:0] {
      ST_INIT, ST_IDLE, ST_SETBUS, ST_START, ST_ADDR, ST_WR, ST_RD, ST_STOP, ST_DONE
   } state_t;

   typedef enum logic [2:0] {
      STS_OK       = 3'd0,
      STS_NAK      = 3'd1,
      STS_ARB_LOST = 3'd2,
      STS_ERR      = 3'd3,
      STS_TIMEOUT  = 3'd4
   } status_t;

   // Step within one IICMB command.
   typedef enum logic [2:0] {
      PH_WDAT, PH_DPR, PH_CMD, PH_IRQ, PH_RSP, PH_RDD, PH_CSR0, PH_CSR1
   } phase_t;

endpackage

// File: rtl/wb_i2c_seq_xfer.sv
// Single Wishbone access engine: one access at a time, at least one idle cycle between accesses.
module wb_i2c_seq_xfer
   import i2c_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start,
   input  logic       we,
   input  logic [1:0] adr,
   input  logic [7:0] dat,
   output logic       done,
   output logic [7:0] rdata,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic [1:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i
);

   logic stb;

   // A start seen while done is high belongs to the finishing command and is ignored.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stb      <= 1'b0;
         done     <= 1'b0;
         rdata    <= 8'h00;
         wb_we_o  <= 1'b0;
         wb_adr_o <= 2'd0;
         wb_dat_o <= 8'h00;
      end else begin
         done <= 1'b0;
         if (stb) begin
            if (wb_ack_i) begin
               stb   <= 1'b0;
               done  <= 1'b1;
               rdata <= wb_dat_i;
            end
         end else if (start && !done) begin
            stb      <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
         end
      end
   end

   assign wb_cyc_o = stb;
   assign wb_stb_o = stb;

endmodule

// File: rtl/wb_i2c_sequencer.sv
// I2C transfer sequencer driving an IICMB core over Wishbone.
//
//   state  | meaning
//   INIT   | write CSR=0xC0 after reset
//   IDLE   | req_ready_o high, wait for a request
//   SETBUS | DPR=bus, CMDR=SET_BUS (only when bus changes)
//   START  | CMDR=START
//   ADDR   | DPR={addr,rd}, CMDR=WRITE
//   WR     | take a write byte, DPR=byte, CMDR=WRITE, per byte
//   RD     | CMDR=READ ACK/NACK, then read DPR, per byte
//   STOP   | CMDR=STOP
//   DONE   | done_o pulse, status_o updated
module wb_i2c_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       req_valid_i,
   output logic       req_ready_o,
   input  logic       req_rd_i,
   input  logic [6:0] req_addr_i,
   input  logic [3:0] req_bus_i,
   input  logic [3:0] req_len_i,
   input  logic [7:0] wdata_i,
   input  logic       wdata_valid_i,
   output logic       wdata_ready_o,
   output logic [7:0] rdata_o,
   output logic       rdata_valid_o,
   output logic       done_o,
   output logic [2:0] status_o,
   output logic       wb_cyc_o,
   output logic       wb_stb_o,
   output logic       wb_we_o,
   output logic [1:0] wb_adr_o,
   output logic [7:0] wb_dat_o,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_ack_i,
   input  logic       irq_i
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);

   state_t    st_q, st_d;
   phase_t    ph_q, ph_d;
   status_t   stat_q, stat_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [3:0] cnt_q, cnt_d, len_q, bus_q, last_bus_q, last_bus_d;
   logic       bus_vld_q, bus_vld_d, rd_q;
   logic [6:0] addr_q;
   logic [7:0] wbyte_q, cmd, dpr;
   logic       accept, take_byte, rd_hit, last;

   logic       x_start, x_we, x_done;
   reg_addr_t  x_adr;
   logic [7:0] x_dat, x_rdata;

   wb_i2c_seq_xfer u_xfer (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .start    (x_start),
      .we       (x_we),
      .adr      (x_adr),
      .dat      (x_dat),
      .done     (x_done),
      .rdata    (x_rdata),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q          <= ST_INIT;
         ph_q          <= PH_CSR1;
         stat_q        <= STS_OK;
         status_o      <= 3'd0;
         tmr_q         <= '0;
         cnt_q         <= 4'd0;
         len_q         <= 4'd0;
         bus_q         <= 4'd0;
         last_bus_q    <= 4'd0;
         bus_vld_q     <= 1'b0;
         rd_q          <= 1'b0;
         addr_q        <= 7'd0;
         wbyte_q       <= 8'h00;
         rdata_o       <= 8'h00;
         rdata_valid_o <= 1'b0;
      end else begin
         st_q          <= st_d;
         ph_q          <= ph_d;
         stat_q        <= stat_d;
         tmr_q         <= tmr_d;
         cnt_q         <= cnt_d;
         last_bus_q    <= last_bus_d;
         bus_vld_q     <= bus_vld_d;
         rdata_valid_o <= rd_hit;
         if (rd_hit) rdata_o <= x_rdata;
         if (take_byte) wbyte_q <= wdata_i;
         if (accept) begin
            rd_q   <= req_rd_i;
            addr_q <= req_addr_i;
            bus_q  <= req_bus_i;
            len_q  <= req_len_i;
         end
         if (st_d == ST_DONE && st_q != ST_DONE) status_o <= stat_d;
      end
   end

   always_comb begin
      st_d        = st_q;
      ph_d        = ph_q;
      stat_d      = stat_q;
      tmr_d       = tmr_q;
      cnt_d       = cnt_q;
      last_bus_d  = last_bus_q;
      bus_vld_d   = bus_vld_q;
      req_ready_o   = 1'b0;
      wdata_ready_o = 1'b0;
      done_o        = 1'b0;
      accept      = 1'b0;
      take_byte   = 1'b0;
      rd_hit      = 1'b0;
      x_start     = 1'b0;
      x_we        = 1'b0;
      x_adr       = REG_CSR;
      x_dat       = 8'h00;
      cmd         = CMD_STOP;
      dpr         = wbyte_q;
      last        = (cnt_q == len_q);

      case (st_q)
         ST_SETBUS: begin cmd = CMD_SET_BUS; dpr = {4'h0, bus_q}; end
         ST_START:  cmd = CMD_START;
         ST_ADDR:   begin cmd = CMD_WRITE; dpr = {addr_q, rd_q}; end
         ST_WR:     cmd = CMD_WRITE;
         ST_RD:     cmd = last ? CMD_RD_NAK : CMD_RD_ACK;
         default:   cmd = CMD_STOP;
      endcase

      // IDLE and DONE park in PH_WDAT, which issues no bus access.
      case (ph_q)
         PH_DPR:  begin x_start = 1'b1; x_we = 1'b1; x_adr = REG_DPR;  x_dat = dpr; end
         PH_CMD:  begin x_start = 1'b1; x_we = 1'b1; x_adr = REG_CMDR; x_dat = cmd; end
         PH_RSP:  begin x_start = 1'b1; x_adr = REG_CMDR; end
         PH_RDD:  begin x_start = 1'b1; x_adr = REG_DPR; end
         PH_CSR0: begin x_start = 1'b1; x_we = 1'b1; x_adr = REG_CSR; x_dat = CSR_OFF; end
         PH_CSR1: begin x_start = 1'b1; x_we = 1'b1; x_adr = REG_CSR; x_dat = CSR_ON; end
         default: ;
      endcase

      case (st_q)
         ST_INIT: begin
            if (x_done) begin st_d = ST_IDLE; ph_d = PH_WDAT; end
         end
         ST_IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               accept = 1'b1;
               cnt_d  = 4'd0;
               stat_d = STS_OK;
               if (!bus_vld_q || req_bus_i != last_bus_q) begin
                  st_d = ST_SETBUS; ph_d = PH_DPR;
               end else begin
                  st_d = ST_START; ph_d = PH_CMD;
               end
            end
         end
         ST_DONE: begin
            done_o = 1'b1;
            st_d   = ST_IDLE;
            ph_d   = PH_WDAT;
         end
         default: begin
            case (ph_q)
               PH_WDAT: begin
                  wdata_ready_o = wdata_valid_i;
                  if (wdata_valid_i) begin take_byte = 1'b1; ph_d = PH_DPR; end
               end
               PH_DPR: if (x_done) ph_d = PH_CMD;
               PH_CMD: if (x_done) begin ph_d = PH_IRQ; tmr_d = TMR_LOAD; end
               PH_IRQ: begin
                  if (irq_i) ph_d = PH_RSP;
                  else if (tmr_q == TMR_ONE) begin
                     ph_d = PH_CSR0; stat_d = STS_TIMEOUT; bus_vld_d = 1'b0;
                  end else tmr_d = tmr_q - TMR_ONE;
               end
               PH_RSP: if (x_done) begin
                  if (x_rdata[RSP_AL]) begin
                     stat_d = STS_ARB_LOST; bus_vld_d = 1'b0; st_d = ST_DONE; ph_d = PH_WDAT;
                  end else if (x_rdata[RSP_ERR] || !(x_rdata[RSP_DON] || x_rdata[RSP_NAK])) begin
                     stat_d = STS_ERR; bus_vld_d = 1'b0; st_d = ST_DONE; ph_d = PH_WDAT;
                  end else if (x_rdata[RSP_NAK] && (st_q == ST_ADDR || st_q == ST_WR)) begin
                     stat_d = STS_NAK; st_d = ST_STOP; ph_d = PH_CMD;
                  end else begin
                     case (st_q)
                        ST_SETBUS: begin
                           last_bus_d = bus_q; bus_vld_d = 1'b1; st_d = ST_START; ph_d = PH_CMD;
                        end
                        ST_START: begin st_d = ST_ADDR; ph_d = PH_DPR; end
                        ST_ADDR: begin
                           st_d = rd_q ? ST_RD : ST_WR;
                           ph_d = rd_q ? PH_CMD : PH_WDAT;
                        end
                        ST_WR: begin
                           if (last) begin st_d = ST_STOP; ph_d = PH_CMD; end
                           else begin cnt_d = cnt_q + 4'd1; ph_d = PH_WDAT; end
                        end
                        ST_RD:   ph_d = PH_RDD;
                        default: begin st_d = ST_DONE; ph_d = PH_WDAT; end
                     endcase
                  end
               end
               PH_RDD: if (x_done) begin
                  rd_hit = 1'b1;
                  if (last) begin st_d = ST_STOP; ph_d = PH_CMD; end
                  else begin cnt_d = cnt_q + 4'd1; ph_d = PH_CMD; end
               end
               PH_CSR0: if (x_done) ph_d = PH_CSR1;
               PH_CSR1: if (x_done) begin st_d = ST_DONE; ph_d = PH_WDAT; end
               default: ;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_wb_i2c_sequencer.sv
// Directed bench for wb_i2c_sequencer with a behavioural IICMB Wishbone slave.
`timescale 1ns/1ps
module tb_wb_i2c_sequencer;

   logic       clk, rst_n;
   logic       req_valid_i, req_ready_o, req_rd_i;
   logic [6:0] req_addr_i;
   logic [3:0] req_bus_i, req_len_i;
   logic [7:0] wdata_i, rdata_o;
   logic       wdata_valid_i, wdata_ready_o, rdata_valid_o, done_o;
   logic [2:0] status_o;
   logic       wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i, irq_i;
   logic [1:0] wb_adr_o;
   logic [7:0] wb_dat_o, wb_dat_i;

   wb_i2c_sequencer #(.TIMEOUT_CYC(100)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rd_i(req_rd_i),
      .req_addr_i(req_addr_i), .req_bus_i(req_bus_i), .req_len_i(req_len_i),
      .wdata_i(wdata_i), .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o),
      .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o), .done_o(done_o), .status_o(status_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
      .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .irq_i(irq_i)
   );

   int unsigned vectors = 0, miscompares = 0;
   int unsigned cyc = 0, done_cnt = 0, wready_cnt = 0, b2b_cnt = 0, irq_cnt = 0;
   logic [9:0]  wlog[$], exp_q[$];
   int unsigned wcyc[$];
   logic [7:0]  wq[$], rdq[$], rcap[$];
   logic [7:0]  rsp = 8'h80;
   bit irq_en = 1, nak_arm = 0, spur_irq = 0, wflush = 0, fired = 0;
   int unsigned base, diff;

   initial begin clk = 0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end
   initial begin #3000000; $display("FAIL watchdog expired"); $fatal; end

   // IICMB register model: one-cycle ack, irq three cycles after each CMDR write.
   initial begin
      wb_ack_i = 0; wb_dat_i = 8'h00; irq_i = 0;
      forever begin
         @(negedge clk);
         irq_i = 0;
         if (irq_cnt != 0) begin irq_cnt--; if (irq_cnt == 0) irq_i = 1; end
         if (spur_irq) begin irq_i = 1; spur_irq = 0; end
         if (wb_ack_i) begin
            wb_ack_i = 0;
            if (wb_stb_o) b2b_cnt++;
         end else if (wb_stb_o) begin
            wb_ack_i = 1;
            if (wb_cyc_o !== 1'b1) b2b_cnt++;
            if (wb_we_o) begin
               wlog.push_back({wb_adr_o, wb_dat_o});
               wcyc.push_back(cyc);
               if (wb_adr_o == 2'd2) begin
                  rsp = 8'h80;
                  if (nak_arm && wb_dat_o == 8'h01) begin rsp = 8'hC0; nak_arm = 0; end
                  if (irq_en) irq_cnt = 3;
               end
            end else if (wb_adr_o == 2'd2) wb_dat_i = rsp;
            else if (wb_adr_o == 2'd1) wb_dat_i = (rdq.size() > 0) ? rdq.pop_front() : 8'hEE;
            else wb_dat_i = 8'h00;
         end
      end
   end

   // Write-byte source and output monitors.
   initial begin
      wdata_valid_i = 0; wdata_i = 8'h00;
      forever begin
         @(negedge clk);
         if (done_o) done_cnt++;
         if (rdata_valid_o) rcap.push_back(rdata_o);
         if (wflush) begin wq.delete(); wdata_valid_i = 0; fired = 0; wflush = 0; end
         if (fired) begin fired = 0; wdata_valid_i = 0; end
         if (!wdata_valid_i && wq.size() > 0) begin wdata_i = wq.pop_front(); wdata_valid_i = 1; end
         #1;
         if (wdata_valid_i && wdata_ready_o) begin fired = 1; wready_cnt++; end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, 32'(wlog.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wlog.size(); i++)
         check($sformatf("%s[%0d]", tag, i), 32'(wlog[i]), 32'(exp_q[i]));
      wlog.delete(); wcyc.delete();
   endtask

   task automatic wait_ready(input string tag);
      bit ok = 0;
      for (int i = 0; i < 500 && !ok; i++) begin @(negedge clk); #1; if (req_ready_o) ok = 1; end
      if (!ok) check(tag, 32'(req_ready_o), 32'd1);
   endtask

   task automatic do_req(input logic rd, input logic [6:0] a, input logic [3:0] b, input logic [3:0] l);
      bit ok = 0;
      @(negedge clk);
      req_rd_i = rd; req_addr_i = a; req_bus_i = b; req_len_i = l; req_valid_i = 1;
      for (int i = 0; i < 500 && !ok; i++) begin #1; if (req_ready_o) ok = 1; @(negedge clk); end
      req_valid_i = 0;
      if (!ok) check("req_accept", 32'(req_ready_o), 32'd1);
   endtask

   task automatic wait_done(input string tag);
      int unsigned b = done_cnt;
      bit ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); #2; if (done_cnt != b) ok = 1; end
      if (!ok) check(tag, done_cnt, b + 1);
   endtask

   initial begin
      rst_n = 0; req_valid_i = 0; req_rd_i = 0; req_addr_i = 0; req_bus_i = 0; req_len_i = 0;
      repeat (3) @(negedge clk);
      check("rst_ready",  32'(req_ready_o), 32'd0);
      check("rst_cyc",    32'(wb_cyc_o),    32'd0);
      check("rst_done",   32'(done_o),      32'd0);
      check("rst_status", 32'(status_o),    32'd0);
      rst_n = 1;
      wait_ready("init_ready");

      // Write 0xAB,0xCD to 0x22 on bus 0
      wq.push_back(8'hAB); wq.push_back(8'hCD);
      base = wready_cnt;
      do_req(1'b0, 7'h22, 4'd0, 4'd1); wait_done("t1_done");
      check("t1_status", 32'(status_o), 32'd0);
      check("t1_wready", wready_cnt - base, 32'd2);
      exp_q = {10'h0C0, 10'h100, 10'h206, 10'h204, 10'h144, 10'h201,
               10'h1AB, 10'h201, 10'h1CD, 10'h201, 10'h205};
      check_log("t1_log");

      // Read three bytes from 0x22, with a stray irq while idle
      spur_irq = 1; repeat (3) @(negedge clk);
      rdq.push_back(8'h11); rdq.push_back(8'h22); rdq.push_back(8'h33);
      do_req(1'b1, 7'h22, 4'd0, 4'd2); wait_done("t2_done");
      check("t2_status", 32'(status_o), 32'd0);
      check("t2_nbytes", 32'(rcap.size()), 32'd3);
      if (rcap.size() == 3) begin
         check("t2_byte0", 32'(rcap[0]), 32'h11);
         check("t2_byte1", 32'(rcap[1]), 32'h22);
         check("t2_byte2", 32'(rcap[2]), 32'h33);
      end
      exp_q = {10'h204, 10'h145, 10'h201, 10'h202, 10'h202, 10'h203, 10'h205};
      check_log("t2_log");

      // Two single-byte writes on bus 3: SETBUS only on the first
      wq.push_back(8'h5A);
      do_req(1'b0, 7'h10, 4'd3, 4'd0); wait_done("t3a_done");
      wq.push_back(8'h5B);
      do_req(1'b0, 7'h10, 4'd3, 4'd0); wait_done("t3b_done");
      check("t3_status", 32'(status_o), 32'd0);
      exp_q = {10'h103, 10'h206, 10'h204, 10'h120, 10'h201, 10'h15A, 10'h201, 10'h205,
               10'h204, 10'h120, 10'h201, 10'h15B, 10'h201, 10'h205};
      check_log("t3_log");

      // Address NAK: STOP, status NAK, no byte consumed
      nak_arm = 1;
      wq.push_back(8'h77); wq.push_back(8'h88);
      base = wready_cnt;
      do_req(1'b0, 7'h33, 4'd3, 4'd1); wait_done("t4_done");
      check("t4_status", 32'(status_o), 32'd1);
      check("t4_wready", wready_cnt - base, 32'd0);
      exp_q = {10'h204, 10'h166, 10'h201, 10'h205};
      check_log("t4_log");
      wflush = 1; repeat (3) @(negedge clk);

      // irq withheld: CSR off/on recovery, status TIMEOUT
      irq_en = 0;
      do_req(1'b0, 7'h10, 4'd3, 4'd0); wait_done("t5_done");
      check("t5_status", 32'(status_o), 32'd4);
      diff = (wcyc.size() >= 2) ? wcyc[1] - wcyc[0] : 0;
      check("t5_wait_window", 32'(diff >= 100 && diff <= 110), 32'd1);
      exp_q = {10'h204, 10'h000, 10'h0C0};
      check_log("t5_log");
      irq_en = 1;

      // Reset in the middle of a write; bus record was invalidated by the timeout
      wq.push_back(8'h99);
      base = wready_cnt;
      do_req(1'b0, 7'h10, 4'd3, 4'd2);
      for (int i = 0; i < 500 && wready_cnt == base; i++) @(negedge clk);
      repeat (30) @(negedge clk);
      exp_q = {10'h103, 10'h206, 10'h204, 10'h120, 10'h201, 10'h199, 10'h201};
      check_log("t6_log");
      #2 rst_n = 0;
      #1;
      check("t6_rst_cyc",    32'(wb_cyc_o),    32'd0);
      check("t6_rst_ready",  32'(req_ready_o), 32'd0);
      check("t6_rst_status", 32'(status_o),    32'd0);
      check("t6_rst_wready", 32'(wdata_ready_o), 32'd0);
      repeat (3) @(negedge clk);
      wlog.delete(); wcyc.delete();
      rst_n = 1;
      wait_ready("t6_reinit");
      wq.push_back(8'h42);
      do_req(1'b0, 7'h10, 4'd3, 4'd0); wait_done("t7_done");
      check("t7_status", 32'(status_o), 32'd0);
      exp_q = {10'h0C0, 10'h103, 10'h206, 10'h204, 10'h120, 10'h201, 10'h142, 10'h201, 10'h205};
      check_log("t7_log");

      check("done_pulses", done_cnt, 32'd7);
      check("wb_spacing",  b2b_cnt,  32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/wb_i2c_sequencer.md
WB_I2C_SEQUENCER -- requirements
Module: wb_i2c_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 20000: max cycles waited for irq_i per IICMB command.
REQ-002 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid_i  in  1  transfer request valid.
REQ-005 SHALL have port req_ready_o  out  1  request accepted when valid&ready.
REQ-006 SHALL have port req_rd_i  in  1  1=I2C read, 0=I2C write.
REQ-007 SHALL have port req_addr_i  in  7  I2C slave address.
REQ-008 SHALL have port req_bus_i  in  4  IICMB bus select.
REQ-009 SHALL have port req_len_i  in  4  byte count minus one (1..16 bytes).
REQ-010 SHALL have port wdata_i  in  8  write byte.
REQ-011 SHALL have port wdata_valid_i  in  1  write byte valid.
REQ-012 SHALL have port wdata_ready_o  out  1  write byte consumed when valid&ready.
REQ-013 SHALL have port rdata_o  out  8  read byte.
REQ-014 SHALL have port rdata_valid_o  out  1  one-cycle read byte strobe.
REQ-015 SHALL have port done_o  out  1  one-cycle transfer-complete pulse.
REQ-016 SHALL have port status_o  out  3  OK=0, NAK=1, ARB_LOST=2, ERR=3, TIMEOUT=4; held until next done_o.
REQ-017 SHALL have ports wb_cyc_o/wb_stb_o  out  1 each  Wishbone cycle/strobe, driven identically.
REQ-018 SHALL have port wb_we_o  out  1  Wishbone write enable.
REQ-019 SHALL have port wb_adr_o  out  2  register address: CSR=0, DPR=1, CMDR=2, FSMR=3.
REQ-020 SHALL have port wb_dat_o  out  8  Wishbone write data.
REQ-021 SHALL have ports wb_dat_i  in  8 and wb_ack_i  in  1  Wishbone read data and ack.
REQ-022 SHALL have port irq_i  in  1  IICMB command-done interrupt.

Function
REQ-023 SHALL perform one Wishbone access at a time; stb held until ack, dropped the cycle after ack; no back-to-back access without one idle cycle.
REQ-024 After reset SHALL write CSR=0xC0 (enable, IE) before asserting req_ready_o.
REQ-025 States: INIT, IDLE, SETBUS, START, ADDR, WR, RD, STOP, DONE.
REQ-026 IDLE: req_ready_o=1; accept latches rd/addr/bus/len and byte counter=0.
REQ-027 SETBUS issued (DPR=bus, CMDR=0x06) only if bus differs from last set bus or first transfer after INIT; else go directly to START.
REQ-028 Per command: optional DPR write, CMDR write, wait irq_i, CMDR read; response bit7 DON, bit6 NAK, bit5 AL, bit4 ERR.
REQ-029 START: CMDR=0x04. ADDR: DPR={addr,rd}, CMDR=0x01.
REQ-030 WR: wait wdata_valid_i, pulse wdata_ready_o one cycle, DPR=byte, CMDR=0x01; repeat len+1 times.
REQ-031 RD: CMDR=0x02 (ACK) for non-last bytes, 0x03 (NACK) for last; then read DPR and pulse rdata_valid_o with byte.
REQ-032 STOP: CMDR=0x05, then DONE; DONE pulses done_o, returns to IDLE.
REQ-033 NAK on ADDR/WR: issue STOP, status NAK, remaining bytes skipped (wdata not consumed).
REQ-034 AL or ERR response: no STOP, status ARB_LOST/ERR, set-bus record invalidated.
REQ-035 Timeout counter reset per command; expiry: write CSR=0x00 then 0xC0, status TIMEOUT, set-bus record invalidated.
REQ-036 irq_i asserted in a state not awaiting it SHALL be ignored.

Reset
REQ-037 rst_n_i low SHALL asynchronously force INIT, all strobes/ready/done/wb_cyc/wb_stb 0, status_o 0, wb_adr/wb_dat_o 0, counters 0; mid-transfer reset abandons transfer without STOP.

Structure
REQ-038 Package i2c_seq_pkg SHALL hold register addresses, command codes, response bit indices, state enum, status enum.
REQ-039 Sub-module wb_i2c_seq_xfer SHALL implement the single Wishbone access (REQ-023) with start/done handshake.

Verification
REQ-040 Write addr 0x22, bus 0, len 1, bytes 0xAB,0xCD -> CSR 0xC0, SETBUS, START, DPR 0x44, two writes, STOP; done_o, status 0.
REQ-041 Read addr 0x22, len 2, slave returns 0x11,0x22,0x33 -> CMDR 0x02,0x02,0x03; three rdata_valid_o pulses with those bytes; status 0.
REQ-042 Two writes on bus 3 back-to-back -> SETBUS issued only for the first.
REQ-043 Address NAK -> STOP issued, status 1, no wdata_ready_o pulse.
REQ-044 irq_i withheld, TIMEOUT_CYC=100 -> after 100 cycles CSR 0x00 then 0xC0, status 4.
REQ-045 rst_n_i low during WR -> outputs reset immediately; CSR 0xC0 reissued after release.
